// File: rtl/charmatrix_pkg.sv
// Shared constants and FSM encoding for the 5x7 character-matrix LED strip.
package charmatrix_pkg;
   localparam int CHAR_LEDS = 35;
   localparam int MAX_CHARS = 8;
   localparam int GRB_W     = 24;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      COMPOSE,
      OFFER,
      TAKEN
   } state_t;
endpackage

// File: rtl/ledstrip_scheduler_refresh_timer.sv
// Free-running refresh counter plus the sticky refresh-request flag.
module refresh_timer #(
   parameter int REFRESH_CYCLES = 131072
) (
   input  logic clk,
   input  logic reset,
   input  logic update,
   input  logic consume,
   output logic pending
);
   localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

   logic [CW-1:0] count;
   logic          wrap;

   assign wrap = (count == LAST);

   // New requests take priority over the clear so none arriving with it is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         pending <= 1'b1;
      end else begin
         count <= wrap ? '0 : count + 1'b1;
         if (update || wrap)
            pending <= 1'b1;
         else if (consume)
            pending <= 1'b0;
      end
   end
endmodule

// File: rtl/ledstrip_scheduler.sv
// Frame sequencer: walks every LED of the character matrix and hands GRB words
// to the serial driver over a valid/ready handshake.
module ledstrip_scheduler #(
   parameter int NUM_CHARS      = 4,
   parameter int CHAR_LEDS      = charmatrix_pkg::CHAR_LEDS,
   parameter int REFRESH_CYCLES = 131072
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              update,
   output logic [2:0]                        buf_index,
   input  logic [7:0]                        buf_char,
   input  logic [3:0]                        buf_color,
   output logic [7:0]                        char_index,
   input  logic [CHAR_LEDS-1:0]              char_bits,
   output logic [3:0]                        color_index,
   input  logic [charmatrix_pkg::GRB_W-1:0]  color_rgb,
   output logic [charmatrix_pkg::GRB_W-1:0]  pix_data,
   output logic                              pix_valid,
   output logic                              pix_latch,
   input  logic                              pix_ready,
   output logic                              busy,
   output logic                              frame_done
);
   import charmatrix_pkg::*;

   localparam logic [8:0] LAST_LED      = 9'(NUM_CHARS * CHAR_LEDS - 1);
   localparam logic [5:0] LAST_CHAR_LED = 6'(CHAR_LEDS - 1);

   state_t     state, state_next;
   logic       pending;
   logic       consume, do_fetch, do_compose, do_offer, do_take;
   logic [8:0] led_index;
   logic [5:0] char_led;
   logic       last_led, led_wrap;

   assign last_led = (led_index == LAST_LED);
   assign led_wrap = (char_led == LAST_CHAR_LED);

   refresh_timer #(
      .REFRESH_CYCLES(REFRESH_CYCLES)
   ) u_refresh_timer (
      .clk    (clk),
      .reset  (reset),
      .update (update),
      .consume(consume),
      .pending(pending)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pending) state_next = FETCH;
         FETCH:   state_next = COMPOSE;
         COMPOSE: state_next = OFFER;
         OFFER:   if (pix_ready) state_next = TAKEN;
         TAKEN:   if (!pix_ready) state_next = last_led ? IDLE : FETCH;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      consume    = 1'b0;
      do_fetch   = 1'b0;
      do_compose = 1'b0;
      do_offer   = 1'b0;
      do_take    = 1'b0;
      case (state)
         IDLE:    consume    = pending;
         FETCH:   do_fetch   = 1'b1;
         COMPOSE: do_compose = 1'b1;
         OFFER:   do_offer   = pix_ready;
         TAKEN:   do_take    = !pix_ready;
         default: ;
      endcase
   end

   // Pixel word and latch are loaded before the offer, so they hold for the whole valid period.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_index   <= '0;
         char_led    <= '0;
         buf_index   <= '0;
         char_index  <= '0;
         color_index <= '0;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         pix_latch   <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (consume) begin
            led_index <= '0;
            char_led  <= '0;
            buf_index <= '0;
            busy      <= 1'b1;
         end
         if (do_fetch) begin
            char_index  <= buf_char;
            color_index <= buf_color;
         end
         if (do_compose) begin
            pix_data  <= char_bits[char_led] ? color_rgb : '0;
            pix_latch <= last_led;
         end
         if (do_offer)
            pix_valid <= 1'b1;
         if (do_take) begin
            pix_valid <= 1'b0;
            pix_latch <= 1'b0;
            led_index <= led_index + 1'b1;
            if (led_wrap) begin
               char_led  <= '0;
               buf_index <= buf_index + 1'b1;
            end else begin
               char_led <= char_led + 1'b1;
            end
            if (last_led) begin
               busy       <= 1'b0;
               frame_done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ledstrip_scheduler.sv
// Directed bench for ledstrip_scheduler with a fast refresh period and simple ROM/driver models.
module tb_ledstrip_scheduler;
   logic        clk = 1'b0;
   logic        reset;
   logic        update;
   logic [2:0]  buf_index;
   logic [7:0]  buf_char;
   logic [3:0]  buf_color;
   logic [7:0]  char_index;
   logic [34:0] char_bits;
   logic [3:0]  color_index;
   logic [23:0] color_rgb;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_latch;
   logic        pix_ready;
   logic        busy;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fd_count = 0;

   logic [23:0] pix1 [140];
   logic        lat1 [140];
   logic [7:0]  ci1  [140];

   ledstrip_scheduler #(
      .NUM_CHARS     (4),
      .CHAR_LEDS     (35),
      .REFRESH_CYCLES(1000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .update     (update),
      .buf_index  (buf_index),
      .buf_char   (buf_char),
      .buf_color  (buf_color),
      .char_index (char_index),
      .char_bits  (char_bits),
      .color_index(color_index),
      .color_rgb  (color_rgb),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_latch  (pix_latch),
      .pix_ready  (pix_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #25 clk = ~clk;

   always @(posedge clk) begin
      if (reset) cyc = 0;
      else       cyc = cyc + 1;
   end

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_count = fd_count + 1;
   end

   // Text buffer: "AB A" with colours 2, 5, 7, 9.
   always_comb begin
      case (buf_index)
         3'd0:    {buf_char, buf_color} = {8'h41, 4'd2};
         3'd1:    {buf_char, buf_color} = {8'h42, 4'd5};
         3'd2:    {buf_char, buf_color} = {8'h20, 4'd7};
         3'd3:    {buf_char, buf_color} = {8'h41, 4'd9};
         default: {buf_char, buf_color} = {8'h00, 4'd0};
      endcase
   end

   assign char_bits = (char_index == 8'h41) ? 35'h1 :
                      (char_index == 8'h42) ? 35'h4_0000_0002 : 35'h0;
   assign color_rgb = {8'h11 * {4'h0, color_index}, 8'hC0, {4'h0, 4'hF ^ color_index}};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (pix_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_busy(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (busy === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Driver model: take the offered pixel, drop ready, raise it again unless hold is set.
   task automatic take_pixel(input bit hold, output logic [23:0] d, output logic l,
                             output logic [7:0] ci, output bit ok);
      d  = 'x;
      l  = 1'bx;
      ci = 'x;
      wait_valid(20, ok);
      if (!ok) return;
      d  = pix_data;
      l  = pix_latch;
      ci = char_index;
      pix_ready = 1'b0;
      @(negedge clk);
      ok = (pix_valid === 1'b0);
      if (!hold) pix_ready = 1'b1;
   endtask

   task automatic pulse_update();
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
   endtask

   initial begin
      logic [23:0] d;
      logic        l;
      logic [7:0]  ci;
      logic [23:0] stall_data;
      bit          ok;
      int          s1, hs, nz, lat_cnt, ci_bad, bad;

      reset = 1'b1;
      update = 1'b0;
      pix_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_flags", {pix_valid, pix_latch, busy, frame_done}, 4'b0000);
      chk("rst_pix_data", pix_data, 24'h0);
      chk("rst_indices", {buf_index, char_index, color_index}, 15'h0);

      // Frame 1: follows reset because pending starts set.
      reset = 1'b0;
      @(negedge clk);
      chk("busy_after_reset", busy, 1'b1);
      s1 = cyc;
      hs = 0;
      for (int p = 0; p < 140; p++) begin
         take_pixel(1'b0, d, l, ci, ok);
         if (!ok) break;
         hs++;
         pix1[p] = d;
         lat1[p] = l;
         ci1[p]  = ci;
      end
      chk("f1_handshakes", hs, 140);
      chk("f1_frame_done", frame_done, 1'b1);
      chk("f1_busy_low", busy, 1'b0);
      @(negedge clk);
      chk("f1_done_one_cycle", frame_done, 1'b0);
      nz = 0;
      lat_cnt = 0;
      ci_bad = 0;
      for (int p = 0; p < 140; p++) begin
         if (pix1[p] !== 24'h0) nz++;
         if (lat1[p] === 1'b1) lat_cnt++;
         if (p < 35 && ci1[p] !== 8'h41) ci_bad++;
      end
      chk("f1_pix0", pix1[0], 24'h22C00D);
      chk("f1_pix1", pix1[1], 24'h0);
      chk("f1_pix34", pix1[34], 24'h0);
      chk("f1_pix36", pix1[36], 24'h55C00A);
      chk("f1_pix69", pix1[69], 24'h55C00A);
      chk("f1_pix105", pix1[105], 24'h99C006);
      chk("f1_nonzero_count", nz, 4);
      chk("f1_latch_count", lat_cnt, 1);
      chk("f1_latch_last", lat1[139], 1'b1);
      chk("f1_char_index_A", ci_bad, 0);
      chk("f1_char_index_B", ci1[35], 8'h42);

      // Frame 2: periodic start, then a long driver stall on pixel 36.
      wait_busy(1000, ok);
      chk("f2_started", ok, 1'b1);
      chk("f2_period", cyc - s1, 1000);
      hs = 0;
      for (int p = 0; p < 36; p++) begin
         take_pixel(p == 35, d, l, ci, ok);
         if (!ok) break;
         hs++;
      end
      repeat (3) @(negedge clk);
      stall_data = pix_data;
      chk("stall_data", stall_data, 24'h55C00A);
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (pix_valid !== 1'b0 || pix_data !== stall_data) bad++;
      end
      chk("stall_hold", bad, 0);
      pix_ready = 1'b1;
      take_pixel(1'b0, d, l, ci, ok);
      chk("stall_handshake", ok, 1'b1);
      chk("stall_pixel", d, 24'h55C00A);
      if (ok) hs++;
      for (int p = 37; p < 140; p++) begin
         if (p == 50 || p == 80 || p == 110) pulse_update();
         take_pixel(1'b0, d, l, ci, ok);
         if (!ok) break;
         hs++;
      end
      chk("f2_handshakes", hs, 140);
      chk("f2_frame_done", frame_done, 1'b1);
      @(negedge clk);
      chk("f3_starts_after_done", busy, 1'b1);

      // Frame 3: the single collapsed extra frame.
      hs = 0;
      for (int p = 0; p < 140; p++) begin
         take_pixel(1'b0, d, l, ci, ok);
         if (!ok) break;
         hs++;
      end
      chk("f3_handshakes", hs, 140);
      chk("f3_frame_done", frame_done, 1'b1);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy !== 1'b0) bad++;
      end
      chk("no_second_extra", bad, 0);
      chk("frame_done_total", fd_count, 3);

      // Frame 4: periodic again, then reset while pixel 37 is offered.
      wait_busy(1000, ok);
      chk("f4_started", ok, 1'b1);
      chk("f4_period", cyc - s1, 3000);
      hs = 0;
      for (int p = 0; p < 37; p++) begin
         take_pixel(1'b0, d, l, ci, ok);
         if (!ok) break;
         hs++;
      end
      chk("f4_pre_reset_hs", hs, 37);
      wait_valid(20, ok);
      chk("p37_valid", ok, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_flags", {pix_valid, pix_latch, busy, frame_done}, 4'b0000);
      chk("mid_rst_pix_data", pix_data, 24'h0);
      chk("mid_rst_indices", {buf_index, char_index, color_index}, 15'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("restart_busy", busy, 1'b1);
      take_pixel(1'b0, d, l, ci, ok);
      chk("restart_hs", ok, 1'b1);
      chk("restart_pix0", d, 24'h22C00D);
      chk("restart_char", ci, 8'h41);
      chk("restart_latch", l, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
